// File: rtl/usf_sample_feeder.sv
// usf_sample_feeder: buffers ADC codes from a valid/ready source in a small
// FIFO and issues them one at a time to the recovery core as a held sample
// plus a one-cycle strobe, with at least MIN_GAP clocks between strobes.
// Optional macro USF_FEED_OFFSET_EN: codes are offset binary and the MSB is
// inverted on the way into the FIFO so out_sample is two's complement.
`timescale 1ns/1ps
module usf_sample_feeder #(
  parameter int ADC_RES    = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int MIN_GAP    = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          adc_valid,
  input  logic [ADC_RES-1:0]            adc_data,
  output logic                          adc_ready,
  output logic [ADC_RES-1:0]            out_sample,
  output logic                          out_en,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          underrun
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int GAP_W  = $clog2(MIN_GAP + 1);
  localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(MIN_GAP - 1);

  logic [ADC_RES-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [FILL_W-1:0]  fill_reg;
  logic [FILL_W-1:0]  fill_next;
  logic [GAP_W-1:0]   gap_reg;
  logic [ADC_RES-1:0] sample_reg;
  logic               en_reg;
  logic               underrun_reg;
  logic               issued_reg;
  logic [ADC_RES-1:0] wr_data;
  logic               full;
  logic               empty;
  logic               gap_zero;
  logic               push;
  logic               issue;

  // Status is derived from occupancy so a full FIFO is never mistaken for empty.
  assign full      = (fill_reg == FULL_LVL);
  assign empty     = (fill_reg == '0);
  assign gap_zero  = (gap_reg == '0);
  assign adc_ready = !full;
  assign push      = adc_valid && !full;
  assign issue     = run && !empty && gap_zero;

`ifdef USF_FEED_OFFSET_EN
  assign wr_data = {~adc_data[ADC_RES-1], adc_data[ADC_RES-2:0]};
`else
  assign wr_data = adc_data;
`endif

  // Next occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    fill_next = fill_reg;
    if (push && !issue) begin
      fill_next = fill_reg + FILL_W'(1);
    end else if (issue && !push) begin
      fill_next = fill_reg - FILL_W'(1);
    end
  end

  // Sample storage; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      fill_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (issue) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      fill_reg <= fill_next;
    end
  end

  // Output register: the popped head is held until the next issue; strobe lasts one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_reg <= '0;
      en_reg     <= 1'b0;
    end else begin
      en_reg <= issue;
      if (issue) begin
        sample_reg <= mem[rd_ptr_reg];
      end
    end
  end

  // Spacing counter: reloaded on issue, runs down every cycle irrespective of run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_reg <= '0;
    end else if (issue) begin
      gap_reg <= GAP_LOAD;
    end else if (!gap_zero) begin
      gap_reg <= gap_reg - GAP_W'(1);
    end
  end

  // Sticky underrun: the core was ready for a sample after streaming began but none was buffered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued_reg   <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      if (issue) begin
        issued_reg <= 1'b1;
      end
      if (run && gap_zero && empty && issued_reg) begin
        underrun_reg <= 1'b1;
      end
    end
  end

  assign out_sample = sample_reg;
  assign out_en     = en_reg;
  assign fill       = fill_reg;
  assign underrun   = underrun_reg;

endmodule

// File: tb/tb_usf_sample_feeder.sv
// Testbench for usf_sample_feeder: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_usf_sample_feeder;

  localparam int ADC_RES    = 12;
  localparam int FIFO_DEPTH = 8;
  localparam int MIN_GAP    = 5;
  localparam int FILL_W     = $clog2(FIFO_DEPTH) + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               run = 1'b0;
  logic               adc_valid = 1'b0;
  logic [ADC_RES-1:0] adc_data = '0;
  logic               adc_ready;
  logic [ADC_RES-1:0] out_sample;
  logic               out_en;
  logic [FILL_W-1:0]  fill;
  logic               underrun;

  int n_checks = 0;
  int n_pass   = 0;

  usf_sample_feeder #(
    .ADC_RES(ADC_RES),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MIN_GAP(MIN_GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .run(run),
    .adc_valid(adc_valid),
    .adc_data(adc_data),
    .adc_ready(adc_ready),
    .out_sample(out_sample),
    .out_en(out_en),
    .fill(fill),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [ADC_RES-1:0] xf(input logic [ADC_RES-1:0] d);
`ifdef USF_FEED_OFFSET_EN
    return {~d[ADC_RES-1], d[ADC_RES-2:0]};
`else
    return d;
`endif
  endfunction

  // Behavioural model: FIFO as a queue, spacing as elapsed cycles since last issue.
  logic [ADC_RES-1:0] m_q[$];
  logic               m_en = 1'b0;
  logic [ADC_RES-1:0] m_sample = '0;
  logic               m_und = 1'b0;
  logic               m_issued = 1'b0;
  int                 m_cycle = 0;
  int                 m_last = -1000;

  initial begin
    bit gz;
    bit do_push;
    bit do_issue;
    forever begin
      @(posedge clk);
      if (!reset) begin
        m_q.delete();
        m_en = 1'b0; m_sample = '0; m_und = 1'b0; m_issued = 1'b0;
        m_cycle = 0; m_last = -1000;
      end else begin
        gz       = (m_cycle - m_last) >= MIN_GAP;
        do_push  = adc_valid && (m_q.size() < FIFO_DEPTH);
        do_issue = run && (m_q.size() > 0) && gz;
        if (run && gz && (m_q.size() == 0) && m_issued) m_und = 1'b1;
        m_en = do_issue;
        if (do_issue) begin
          m_sample = m_q.pop_front();
          m_last   = m_cycle;
          m_issued = 1'b1;
        end
        if (do_push) m_q.push_back(xf(adc_data));
        m_cycle++;
      end
    end
  end

  // Compare DUT against the model on every cycle out of reset.
  always @(negedge clk) begin
    if (reset) begin
      chk("m_ready",    32'(adc_ready),  32'(m_q.size() < FIFO_DEPTH));
      chk("m_fill",     32'(fill),       32'(m_q.size()));
      chk("m_out_en",   32'(out_en),     32'(m_en));
      chk("m_sample",   32'(out_sample), 32'(m_sample));
      chk("m_underrun", 32'(underrun),   32'(m_und));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    run = 1'b0; adc_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_pulse(input string name, input logic [ADC_RES-1:0] exp);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (out_en) begin seen = 1'b1; break; end
    end
    if (!seen) chk({name, "_timeout"}, 32'(0), 32'(1));
    else       chk(name, 32'(out_sample), 32'(exp));
  endtask

  initial begin
    int cnt;
    int maxf;
    int idx;
    int k;
    int np;
    int pt[3];
    logic [ADC_RES-1:0] pv[3];
    bit acc;

    // Reset state, checked while reset is held.
    #2 reset = 1'b0;
    #1;
    chk("rst_ready", 32'(adc_ready), 32'(1));
    chk("rst_fill", 32'(fill), 32'(0));
    chk("rst_out_en", 32'(out_en), 32'(0));
    chk("rst_sample", 32'(out_sample), 32'(0));
    chk("rst_underrun", 32'(underrun), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // Single code: two-cycle latency, one pulse, underrun MIN_GAP cycles later.
    run = 1'b1; adc_valid = 1'b1; adc_data = 12'h123;
    step();
    adc_valid = 1'b0;
    chk("t1_latency", 32'(out_en), 32'(0));
    step();
    chk("t1_en", 32'(out_en), 32'(1));
    chk("t1_sample", 32'(out_sample), 32'(xf(12'h123)));
    cnt = 0;
    for (int i = 0; i < MIN_GAP - 1; i++) begin
      step();
      cnt += int'(out_en);
    end
    chk("t1_underrun_early", 32'(underrun), 32'(0));
    step();
    chk("t1_underrun", 32'(underrun), 32'(1));
    chk("t1_no_extra", 32'(cnt), 32'(0));

    // Three back-to-back codes: pulses exactly MIN_GAP apart, fill peaks at 2.
    do_reset();
    run = 1'b1; maxf = 0; np = 0;
    for (int c = 0; c < 25; c++) begin
      if (c < 3) begin adc_valid = 1'b1; adc_data = ADC_RES'(c + 1); end
      else adc_valid = 1'b0;
      step();
      if (int'(fill) > maxf) maxf = int'(fill);
      if (out_en && np < 3) begin pt[np] = c; pv[np] = out_sample; np++; end
    end
    chk("t2_pulses", 32'(np), 32'(3));
    chk("t2_maxfill", 32'(maxf), 32'(2));
    chk("t2_first_at", 32'(pt[0]), 32'(1));
    for (int i = 0; i < 3; i++) chk("t2_value", 32'(pv[i]), 32'(xf(ADC_RES'(i + 1))));
    chk("t2_gap01", 32'(pt[1] - pt[0]), 32'(MIN_GAP));
    chk("t2_gap12", 32'(pt[2] - pt[1]), 32'(MIN_GAP));

    // Fill to full with run low; ninth code waits upstream.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      adc_valid = 1'b1; adc_data = ADC_RES'(12'h010 + i);
      step();
    end
    chk("t3_full_fill", 32'(fill), 32'(8));
    chk("t3_full_ready", 32'(adc_ready), 32'(0));
    adc_data = 12'h018;
    step();
    step();
    chk("t3_held_fill", 32'(fill), 32'(8));
    run = 1'b1;
    step();
    chk("t3_first_en", 32'(out_en), 32'(1));
    chk("t3_first_val", 32'(out_sample), 32'(xf(12'h010)));
    chk("t3_ready_after_pop", 32'(adc_ready), 32'(1));
    step();
    adc_valid = 1'b0;
    chk("t3_ninth_in", 32'(fill), 32'(8));
    for (int j = 1; j < 9; j++) wait_pulse("t3_order", xf(ADC_RES'(12'h010 + j)));

    // Valid held against a full FIFO while draining: 0..15 exactly once each.
    do_reset();
    idx = 0; k = 0;
    for (int c = 0; c < 400; c++) begin
      if (idx < 16) begin adc_valid = 1'b1; adc_data = ADC_RES'(idx); end
      else adc_valid = 1'b0;
      acc = adc_valid && adc_ready;
      step();
      if (acc) idx++;
      if (idx >= FIFO_DEPTH) run = 1'b1;
      if (out_en) begin
        chk("t4_seq", 32'(out_sample), 32'(xf(ADC_RES'(k))));
        k++;
        if (k == 16) break;
      end
    end
    chk("t4_count", 32'(k), 32'(16));
    cnt = 0;
    for (int i = 0; i < 3 * MIN_GAP; i++) begin step(); cnt += int'(out_en); end
    chk("t4_no_dup", 32'(cnt), 32'(0));

    // Reset mid-stream with samples buffered.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      adc_valid = 1'b1; adc_data = ADC_RES'(12'h031 + i);
      step();
    end
    adc_valid = 1'b0; run = 1'b1;
    step();
    chk("t5_pre_en", 32'(out_en), 32'(1));
    chk("t5_pre_fill", 32'(fill), 32'(3));
    #2 reset = 1'b0;
    #1;
    chk("t5_en", 32'(out_en), 32'(0));
    chk("t5_fill", 32'(fill), 32'(0));
    chk("t5_sample", 32'(out_sample), 32'(0));
    chk("t5_ready", 32'(adc_ready), 32'(1));
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    cnt = 0; maxf = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      cnt += int'(out_en);
      if (int'(fill) > maxf) maxf = int'(fill);
    end
    chk("t5_no_stale", 32'(cnt), 32'(0));
    chk("t5_stays_empty", 32'(maxf), 32'(0));

    // Code format at the extremes.
    do_reset();
    run = 1'b1; adc_valid = 1'b1; adc_data = 12'hFFF;
    step();
    adc_data = 12'h000;
    step();
    adc_valid = 1'b0;
    chk("t6_en", 32'(out_en), 32'(1));
`ifdef USF_FEED_OFFSET_EN
    chk("t6_first", 32'(out_sample), 32'(12'h7FF));
    wait_pulse("t6_second", 12'h800);
`else
    chk("t6_first", 32'(out_sample), 32'(12'hFFF));
    wait_pulse("t6_second", 12'h000);
`endif

    // Randomized traffic, one mid-run reset; the model checks every cycle.
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      int p_valid;
      int p_run;
      p_valid = int'($urandom_range(10, 90));
      p_run   = int'($urandom_range(40, 100));
      if (blk == 7) do_reset();
      for (int c = 0; c < 200; c++) begin
        adc_valid = ($urandom_range(0, 99) < p_valid);
        adc_data  = ADC_RES'($urandom);
        run       = ($urandom_range(0, 99) < p_run);
        step();
      end
    end
    adc_valid = 1'b0;
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
